// File: rtl/ide_pio_ctrl.sv
// ---------------------------------------------------------------------------
// ide_pio_ctrl
//
// IDE PIO controller for the Zorro/CPU-local IDE window. Decodes the
// configured 64K bank and serves boot ROM reads until the first write to the
// bank. After that, every access runs a timed IDE cycle:
// SETUP -> STROBE (IORDY extension) -> ACK -> RECOVER.
// DTACK_n is generated for every claimed cycle, including ROM reads.
//
// Ports
//   CLKCPU            in   CPU clock; all logic on the rising edge
//   RESET_n           in   asynchronous active-low reset
//   A_HIGH[7:0]       in   CPU A[23:16]
//   A12, A13, A14     in   CS0 / CS1 select; A14 selects the port when N_PORTS=2
//   RW_n, AS_CPU_n    in   CPU read/write and address strobe (synchronised)
//   BASE_IDE[7:0]     in   autoconfig base A[23:16]
//   IDE_CONFIGURED_n  in   0 = bank assigned
//   FAST_MODE         in   timing set select; sampled when a cycle starts
//   IDE_IORDY         in   drive ready (synchronised); 0 extends the strobe
//   ROM_OE_n          out  boot ROM output enable
//   IDE_IOR_n/IOW_n   out  IDE strobes, shared by all ports
//   IDE_CS_n          out  {CS1,CS0} per port; port p uses bits [2p+1:2p]
//   IDE_ACCESS        out  data buffer enable for IDE cycles
//   DATA_LE           out  one-cycle read-data latch pulse
//   DTACK_n           out  CPU acknowledge
//
// Every output is a flop whose next value is decoded from the next state, so
// outputs change on the same edge the FSM enters the state that drives them.
// ---------------------------------------------------------------------------
module ide_pio_ctrl #(
  parameter int N_PORTS     = 1,
  parameter int CNT_W       = 4,
  parameter int T_SETUP     = 2,
  parameter int T_ACTIVE    = 4,
  parameter int T_RECOVER   = 3,
  parameter int T_SETUP_F   = 1,
  parameter int T_ACTIVE_F  = 2,
  parameter int T_RECOVER_F = 1,
  parameter int ROM_WAIT    = 2,
  parameter int IORDY_TO    = 15
) (
  input  logic                   CLKCPU,
  input  logic                   RESET_n,
  input  logic [7:0]             A_HIGH,
  input  logic                   A12,
  input  logic                   A13,
  input  logic                   A14,
  input  logic                   RW_n,
  input  logic                   AS_CPU_n,
  input  logic [7:0]             BASE_IDE,
  input  logic                   IDE_CONFIGURED_n,
  input  logic                   FAST_MODE,
  input  logic                   IDE_IORDY,
  output logic                   ROM_OE_n,
  output logic                   IDE_IOR_n,
  output logic                   IDE_IOW_n,
  output logic [2*N_PORTS-1:0]   IDE_CS_n,
  output logic                   IDE_ACCESS,
  output logic                   DATA_LE,
  output logic                   DTACK_n
);

  localparam int EXT_W = $clog2(IORDY_TO + 2);

  // Counter reload values: a phase of T cycles loads T-1 and ends at zero.
  localparam logic [CNT_W-1:0] SETUP_S_M1   = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] SETUP_F_M1   = CNT_W'(T_SETUP_F - 1);
  localparam logic [CNT_W-1:0] ACTIVE_S_M1  = CNT_W'(T_ACTIVE - 1);
  localparam logic [CNT_W-1:0] ACTIVE_F_M1  = CNT_W'(T_ACTIVE_F - 1);
  localparam logic [CNT_W-1:0] RECOVER_S_M1 = CNT_W'(T_RECOVER - 1);
  localparam logic [CNT_W-1:0] RECOVER_F_M1 = CNT_W'(T_RECOVER_F - 1);
  localparam logic [CNT_W-1:0] ROM_WAIT_M1  = CNT_W'(ROM_WAIT - 1);
  localparam logic [EXT_W-1:0] EXT_MAX      = EXT_W'(IORDY_TO);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROM,
    S_SETUP,
    S_STROBE,
    S_ACK,
    S_RECOVER
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [EXT_W-1:0]       ext_q, ext_d;        // IORDY extension cycles used
  logic                   last_q, last_d;      // current STROBE cycle is the final one
  logic                   rom_mode_q, rom_mode_d;
  logic                   a12_q, a12_d;
  logic                   a13_q, a13_d;
  logic                   a14_q, a14_d;
  logic                   rd_q, rd_d;
  logic                   fast_q, fast_d;

  logic                   rom_oe_n_q, rom_oe_n_d;
  logic                   ior_n_q, ior_n_d;
  logic                   iow_n_q, iow_n_d;
  logic [2*N_PORTS-1:0]   cs_n_q, cs_n_d;
  logic                   access_q, access_d;
  logic                   data_le_q, data_le_d;
  logic                   dtack_n_q, dtack_n_d;

  logic                   hit;
  logic                   port_sel;
  logic [CNT_W-1:0]       recover_m1;

  assign hit        = !IDE_CONFIGURED_n && (A_HIGH == BASE_IDE) && !AS_CPU_n;
  assign recover_m1 = fast_q ? RECOVER_F_M1 : RECOVER_S_M1;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    ext_d      = ext_q;
    last_d     = 1'b0;
    rom_mode_d = rom_mode_q;
    a12_d      = a12_q;
    a13_d      = a13_q;
    a14_d      = a14_q;
    rd_d       = rd_q;
    fast_d     = fast_q;

    case (state_q)
      S_IDLE: begin
        if (hit) begin
          if (rom_mode_q && RW_n) begin
            state_d = S_ROM;
            cnt_d   = ROM_WAIT_M1;
          end else begin
            state_d = S_SETUP;
            a12_d   = A12;
            a13_d   = A13;
            a14_d   = A14;
            rd_d    = RW_n;
            fast_d  = FAST_MODE;
            cnt_d   = FAST_MODE ? SETUP_F_M1 : SETUP_S_M1;
            if (!RW_n) begin
              rom_mode_d = 1'b0;
            end
          end
        end
      end

      S_ROM: begin
        if (AS_CPU_n) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_SETUP: begin
        if (AS_CPU_n) begin
          state_d = S_RECOVER;
          cnt_d   = recover_m1;
        end else if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = fast_q ? ACTIVE_F_M1 : ACTIVE_S_M1;
          ext_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_STROBE: begin
        if (AS_CPU_n) begin
          state_d = S_RECOVER;
          cnt_d   = recover_m1;
        end else if (last_q) begin
          state_d = S_ACK;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_ACK: begin
        if (AS_CPU_n) begin
          state_d = S_RECOVER;
          cnt_d   = recover_m1;
        end
      end

      S_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // IORDY is judged on the edge that opens each strobe cycle at or past the
    // nominal end, so the final cycle is known when it starts and DATA_LE can
    // be registered into it. The extension count saturates at IORDY_TO.
    if (state_d == S_STROBE && cnt_d == '0) begin
      if (IDE_IORDY || ext_d == EXT_MAX) begin
        last_d = 1'b1;
      end else begin
        ext_d = ext_d + 1'b1;
      end
    end

    rom_oe_n_d = (state_d != S_ROM);
    ior_n_d    = !((state_d == S_STROBE) && rd_d);
    iow_n_d    = !((state_d == S_STROBE) && !rd_d);
    access_d   = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_ACK);
    data_le_d  = (state_d == S_STROBE) && last_d && rd_d;
    dtack_n_d  = !((state_d == S_ACK) ||
                   ((state_d == S_ROM) && (state_q == S_ROM) && (cnt_q == '0)));

    // A14 only picks a port when two are present; unused CS bits stay high.
    port_sel = (N_PORTS == 2) && a14_d;
    cs_n_d   = '1;
    if (access_d) begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (p == int'(port_sel)) begin
          cs_n_d[2*p]   = !a12_d;
          cs_n_d[2*p+1] = !a13_d;
        end
      end
    end
  end

  // NOTE: all state and output flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ext_q      <= '0;
      last_q     <= 1'b0;
      rom_mode_q <= 1'b1;
      a12_q      <= 1'b0;
      a13_q      <= 1'b0;
      a14_q      <= 1'b0;
      rd_q       <= 1'b1;
      fast_q     <= 1'b0;
      rom_oe_n_q <= 1'b1;
      ior_n_q    <= 1'b1;
      iow_n_q    <= 1'b1;
      cs_n_q     <= '1;
      access_q   <= 1'b0;
      data_le_q  <= 1'b0;
      dtack_n_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ext_q      <= ext_d;
      last_q     <= last_d;
      rom_mode_q <= rom_mode_d;
      a12_q      <= a12_d;
      a13_q      <= a13_d;
      a14_q      <= a14_d;
      rd_q       <= rd_d;
      fast_q     <= fast_d;
      rom_oe_n_q <= rom_oe_n_d;
      ior_n_q    <= ior_n_d;
      iow_n_q    <= iow_n_d;
      cs_n_q     <= cs_n_d;
      access_q   <= access_d;
      data_le_q  <= data_le_d;
      dtack_n_q  <= dtack_n_d;
    end
  end

  assign ROM_OE_n   = rom_oe_n_q;
  assign IDE_IOR_n  = ior_n_q;
  assign IDE_IOW_n  = iow_n_q;
  assign IDE_CS_n   = cs_n_q;
  assign IDE_ACCESS = access_q;
  assign DATA_LE    = data_le_q;
  assign DTACK_n    = dtack_n_q;

endmodule

// File: tb/tb_ide_pio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ide_pio_ctrl
//
// Self-checking bench for ide_pio_ctrl. u1 uses the default parameters
// (one port); u2 shares every input but has N_PORTS=2 for the port-select
// check. A cycle table covers ROM read, slow write and slow read; hand-written
// sequences cover IORDY extension/timeout, abort, back-to-back recovery,
// fast timing with port 1, and reset in the middle of a strobe.
// ---------------------------------------------------------------------------
module tb_ide_pio_ctrl;

  logic       CLKCPU = 1'b0;
  logic       RESET_n;
  logic [7:0] A_HIGH;
  logic       A12, A13, A14, RW_n, AS_CPU_n;
  logic [7:0] BASE_IDE;
  logic       IDE_CONFIGURED_n, FAST_MODE, IDE_IORDY;

  logic       u1_rom_oe_n, u1_ior_n, u1_iow_n, u1_access, u1_data_le, u1_dtack_n;
  logic [1:0] u1_cs_n;
  logic       u2_rom_oe_n, u2_ior_n, u2_iow_n, u2_access, u2_data_le, u2_dtack_n;
  logic [3:0] u2_cs_n;

  always #5 CLKCPU = ~CLKCPU;

  ide_pio_ctrl u1 (
    .CLKCPU(CLKCPU), .RESET_n(RESET_n), .A_HIGH(A_HIGH), .A12(A12), .A13(A13), .A14(A14),
    .RW_n(RW_n), .AS_CPU_n(AS_CPU_n), .BASE_IDE(BASE_IDE), .IDE_CONFIGURED_n(IDE_CONFIGURED_n),
    .FAST_MODE(FAST_MODE), .IDE_IORDY(IDE_IORDY), .ROM_OE_n(u1_rom_oe_n), .IDE_IOR_n(u1_ior_n),
    .IDE_IOW_n(u1_iow_n), .IDE_CS_n(u1_cs_n), .IDE_ACCESS(u1_access), .DATA_LE(u1_data_le),
    .DTACK_n(u1_dtack_n)
  );

  ide_pio_ctrl #(.N_PORTS(2)) u2 (
    .CLKCPU(CLKCPU), .RESET_n(RESET_n), .A_HIGH(A_HIGH), .A12(A12), .A13(A13), .A14(A14),
    .RW_n(RW_n), .AS_CPU_n(AS_CPU_n), .BASE_IDE(BASE_IDE), .IDE_CONFIGURED_n(IDE_CONFIGURED_n),
    .FAST_MODE(FAST_MODE), .IDE_IORDY(IDE_IORDY), .ROM_OE_n(u2_rom_oe_n), .IDE_IOR_n(u2_ior_n),
    .IDE_IOW_n(u2_iow_n), .IDE_CS_n(u2_cs_n), .IDE_ACCESS(u2_access), .DATA_LE(u2_data_le),
    .DTACK_n(u2_dtack_n)
  );

  // {ROM_OE_n, IOR_n, IOW_n, CS_n[1:0], IDE_ACCESS, DATA_LE, DTACK_n}
  logic [7:0] obs1;
  assign obs1 = {u1_rom_oe_n, u1_ior_n, u1_iow_n, u1_cs_n, u1_access, u1_data_le, u1_dtack_n};

  localparam logic [7:0] IDLE_O = 8'b111_11_001;

  typedef struct {
    logic       as_n;
    logic       rw_n;
    logic       a12;
    logic       a13;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLKCPU);
    #1;
  endtask

  task automatic add(input logic as_n, input logic rw_n, input logic a12, input logic a13,
                     input logic [7:0] exp, input int n);
    vec_t v;
    v.as_n = as_n; v.rw_n = rw_n; v.a12 = a12; v.a13 = a13; v.exp = exp;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic go_idle();
    AS_CPU_n  = 1'b1;
    IDE_IORDY = 1'b1;
    repeat (5) step();
  endtask

  task automatic wait_dtack(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!u1_dtack_n) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1'b1);
  endtask

  // Read with IORDY held low until `release_at` IOR-low cycles have been seen.
  task automatic strobe_run(input int release_at, output int low, output int le_at,
                            output int le_n, output bit done);
    low = 0; le_at = 0; le_n = 0; done = 1'b0;
    A12 = 1'b1; A13 = 1'b0; RW_n = 1'b1; AS_CPU_n = 1'b0;
    for (int i = 0; i < 60; i++) begin
      IDE_IORDY = (low < release_at) ? 1'b0 : 1'b1;
      step();
      if (!u1_ior_n) begin
        low++;
        if (u1_data_le) le_at = low;
      end
      if (u1_data_le) le_n++;
      if (!u1_dtack_n) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  // Counts clocks until IDE_ACCESS rises again after a hit lands in RECOVER.
  task automatic gap_run(output int gap);
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      gap++;
      if (u1_access) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  low, le_at, le_n, gap;
    bit  done;
    logic any_bad;

    RESET_n = 1'b0; A_HIGH = 8'hE9; A12 = 0; A13 = 0; A14 = 0; RW_n = 1'b1; AS_CPU_n = 1'b1;
    BASE_IDE = 8'hE9; IDE_CONFIGURED_n = 1'b0; FAST_MODE = 1'b0; IDE_IORDY = 1'b1;
    repeat (2) step();
    check("reset_outputs", obs1, IDLE_O);
    check("reset_cs_2port", u2_cs_n, 4'hF);
    RESET_n = 1'b1;
    step();

    // Non-decoded accesses: wrong bank, then bank not configured.
    A_HIGH = 8'hE8; AS_CPU_n = 1'b0;
    repeat (3) step();
    check("wrong_bank_ignored", obs1, IDLE_O);
    A_HIGH = 8'hE9; IDE_CONFIGURED_n = 1'b1;
    repeat (3) step();
    check("unconfigured_ignored", obs1, IDLE_O);
    AS_CPU_n = 1'b1; IDE_CONFIGURED_n = 1'b0;
    step();

    // ROM read: OE one clock after the hit, DTACK two clocks after OE.
    add(1, 1, 0, 0, IDLE_O,        1);
    add(0, 1, 0, 0, 8'b011_11_001, 2);
    add(0, 1, 0, 0, 8'b011_11_000, 2);
    add(1, 1, 0, 0, IDLE_O,        2);
    // Slow write, A12=1: CS 2'b10 for 2, IOW low for 4, then DTACK.
    add(0, 0, 1, 0, 8'b111_10_101, 2);
    add(0, 0, 1, 0, 8'b110_10_101, 4);
    add(0, 0, 1, 0, 8'b111_10_100, 2);
    add(1, 0, 1, 0, IDLE_O,        4);
    // Read after the write: IDE cycle, no ROM; DATA_LE on the last IOR cycle.
    add(0, 1, 0, 1, 8'b111_01_101, 2);
    add(0, 1, 0, 1, 8'b101_01_101, 3);
    add(0, 1, 0, 1, 8'b101_01_111, 1);
    add(0, 1, 0, 1, 8'b111_01_100, 1);
    add(1, 1, 0, 1, IDLE_O,        4);

    foreach (vecs[i]) begin
      AS_CPU_n = vecs[i].as_n;
      RW_n     = vecs[i].rw_n;
      A12      = vecs[i].a12;
      A13      = vecs[i].a13;
      step();
      check($sformatf("vec%0d", i), obs1, vecs[i].exp);
    end

    // IORDY low sampled at the edges opening strobe cycles 4..8: 4+5 cycles.
    strobe_run(8, low, le_at, le_n, done);
    check("iordy5_done", done, 1'b1);
    check("iordy5_ior_low", low, 9);
    check("iordy5_le_at", le_at, 9);
    check("iordy5_le_count", le_n, 1);
    go_idle();

    // IORDY stuck low: strobe ends after 4+15 cycles.
    strobe_run(1000, low, le_at, le_n, done);
    check("iordy_to_done", done, 1'b1);
    check("iordy_to_ior_low", low, 19);
    check("iordy_to_le_at", le_at, 19);
    go_idle();

    // Abort: AS rises during STROBE.
    A12 = 1'b1; A13 = 1'b0; RW_n = 1'b1; AS_CPU_n = 1'b0;
    repeat (3) step();
    check("abort_in_strobe", u1_ior_n, 1'b0);
    step();
    AS_CPU_n = 1'b1;
    step();
    check("abort_release", {u1_ior_n, u1_dtack_n, u1_data_le, u1_access}, 4'b1100);
    any_bad = 1'b0;
    repeat (6) begin
      step();
      if (!u1_dtack_n || u1_data_le) any_bad = 1'b1;
    end
    check("abort_no_ack", any_bad, 1'b0);

    // Back-to-back slow writes: recover 3 cycles, then IDLE takes the hit.
    A12 = 1'b1; RW_n = 1'b0; AS_CPU_n = 1'b0;
    wait_dtack("b2b_first_ack");
    AS_CPU_n = 1'b1;
    step();
    check("b2b_recover_idle", obs1, IDLE_O);
    AS_CPU_n = 1'b0;
    gap_run(gap);
    check("b2b_slow_gap", gap, 4);
    wait_dtack("b2b_second_ack");
    go_idle();

    // Fast set, port 1 (A14=1), A13=1: setup 1, strobe 2, recover 1.
    FAST_MODE = 1'b1; A14 = 1'b1; A13 = 1'b1; A12 = 1'b0; RW_n = 1'b0; AS_CPU_n = 1'b0;
    step();
    check("port1_cs", u2_cs_n, 4'b0111);
    check("port1_ignored_1port", u1_cs_n, 2'b01);
    check("fast_setup", {u2_access, u2_iow_n}, 2'b11);
    step();
    check("fast_strobe1", u2_iow_n, 1'b0);
    step();
    check("fast_strobe2", u2_iow_n, 1'b0);
    step();
    check("fast_ack", {u2_iow_n, u2_dtack_n, u2_cs_n}, 6'b10_0111);
    AS_CPU_n = 1'b1;
    step();
    AS_CPU_n = 1'b0;
    gap_run(gap);
    check("fast_recover_gap", gap, 2);
    wait_dtack("fast_second_ack");
    FAST_MODE = 1'b0; A14 = 1'b0; A13 = 1'b0;
    go_idle();

    // Reset in the middle of a read strobe, then ROM is back.
    A12 = 1'b1; RW_n = 1'b1; AS_CPU_n = 1'b0;
    repeat (3) step();
    check("pre_reset_ior", u1_ior_n, 1'b0);
    #2 RESET_n = 1'b0;
    #1;
    check("async_reset_outputs", obs1, IDLE_O);
    check("async_reset_cs2", u2_cs_n, 4'hF);
    AS_CPU_n = 1'b1;
    step();
    RESET_n = 1'b1;
    AS_CPU_n = 1'b0;
    step();
    check("rom_again_oe", {u1_rom_oe_n, u1_ior_n}, 2'b01);
    repeat (2) step();
    check("rom_again_dtack", u1_dtack_n, 1'b0);
    go_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
